serial_parallel: RTL and testbench
==================================

Name: serial_parallel

Overview:
- BPSK receive-side deserializer. Collects one demodulated bit per strobe into a WIDTH-bit word and presents it on a valid/ready output port.
- Bit order matches the transmit serializer: LSB first, bit k of the frame lands in parallel_data[k].
- Sits after the demodulator/bit-slicer and before the receive framing logic.

Parameters:
- WIDTH, 16, word length in bits
- N, 5, bit-counter width; must satisfy 2^N > WIDTH (and 2^N > WIDTH+1 when SP_PARITY_EN is defined)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- serial_in  in  1  demodulated bit stream
- bit_en  in  1  sample strobe; serial_in is valid on cycles with bit_en=1
- start  in  1  frame enable; held high for the whole word
- clear  in  1  synchronous capture flush
- out_ready  in  1  downstream accepts the word
- parallel_data  out  WIDTH  captured word, stable while out_valid=1
- out_valid  out  1  word available
- active  out  1  capture in progress
- done  out  1  one-cycle pulse on word completion
- overrun  out  1  sticky: a completed word was dropped
- parity_err  out  1  parity status of the presented word

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, counter=0, shift register=0, parallel_data=0, out_valid=0, done=0, overrun=0, parity_err=0.
- States:
  - IDLE: active=0. start=1 moves to SHIFT, and a bit is captured in that same cycle if bit_en=1 (the serializer drives bit 0 combinationally on its first start cycle).
  - SHIFT: active=1. Each clk edge with start=1 and bit_en=1 writes serial_in into shift[counter] and increments counter. The sample that reaches the frame length completes the word: set done=1 for one cycle, go to HOLD.
  - HOLD: active=0. Waits for start=0, then returns to IDLE. One word per start assertion; the serializer's held final bit is ignored.
- Frame length: WIDTH samples (WIDTH+1 with SP_PARITY_EN).
- start=0 while in SHIFT: abort, return to IDLE, counter=0, partial word discarded, no done, out_valid unchanged.
- clear=1: highest priority after reset. Returns to IDLE with counter=0, shift=0, overrun=0. parallel_data and out_valid are not affected.
- Output handshake: a transfer occurs on any edge with out_valid=1 and out_ready=1.
  - Completion with out_valid=0: load parallel_data; out_valid=1 on the next cycle.
  - Completion with out_valid=1 and out_ready=1 in the same cycle: old word is consumed, new word is loaded, out_valid stays 1.
  - Completion with out_valid=1 and out_ready=0: new word is dropped, overrun=1 (sticky until clear or reset), parallel_data unchanged.
  - Transfer with no completion: out_valid=0 next cycle; parallel_data keeps its value.
- Latency: last sample edge to out_valid=1 is 1 cycle. done and out_valid rise on the same edge.
- Counter never exceeds the frame length; no wrap.

Optional Feature:
- Macro: SP_PARITY_EN.
- Defined:
  - One extra sample after the WIDTH data bits is the even-parity bit.
  - Frame length is WIDTH+1.
  - parity_err = XOR of the data bits and the parity bit; it loads together with parallel_data.
  - The word is delivered even when parity_err=1.
- Not defined:
  - Frame length is WIDTH.
  - parity_err is tied to 0.

Test Plan:
- Reset mid-word: drive 5 bits, pull rst_n low asynchronously. All outputs read 0 immediately; after release, the next start captures a full fresh word.
- Basic capture, WIDTH=16, out_ready=1: start held with bit_en every cycle, serial_in = LSB-first bits of 16'hA5C3. done pulses once; parallel_data=16'hA5C3 with out_valid=1 one cycle after the 16th sample; active falls at completion.
- Sparse strobe: bit_en=1 every 4th cycle, word 16'h0001. parallel_data=16'h0001; active stays high for 61 cycles.
- Abort and clear: drop start after 7 bits. No done, out_valid stays 0. Restart with word 16'hFFFF and it is captured correctly. clear asserted mid-word returns to IDLE with counter 0.
- Back-pressure: out_ready=0, capture 16'h1234, then capture 16'h5678. overrun=1 and parallel_data=16'h1234. Raise out_ready: out_valid drops. clear resets overrun to 0.
- SP_PARITY_EN: word 16'h0003 with parity bit 0 gives parity_err=0; the same word with parity bit 1 gives parity_err=1. Word delivered in both cases; done arrives after the 17th sample.

Source files
------------

// File: rtl/serial_parallel_if.sv
// Receive-side bit stream / word handshake bundle for serial_parallel.
// master = upstream bit source plus downstream word sink; slave = deserializer.
interface serial_parallel_if #(
  parameter int WIDTH = 16
);
  logic             serial_in;
  logic             bit_en;
  logic             start;
  logic             clear;
  logic             out_ready;
  logic [WIDTH-1:0] parallel_data;
  logic             out_valid;
  logic             active;
  logic             done;
  logic             overrun;
  logic             parity_err;

  modport master (
    output serial_in, bit_en, start, clear, out_ready,
    input  parallel_data, out_valid, active, done, overrun, parity_err
  );

  modport slave (
    input  serial_in, bit_en, start, clear, out_ready,
    output parallel_data, out_valid, active, done, overrun, parity_err
  );
endinterface

// File: rtl/serial_parallel.sv
// BPSK receive deserializer: LSB-first bits into a WIDTH-bit word on a valid/ready port.
// Define SP_PARITY_EN to take one extra even-parity sample per frame and report parity_err.
module serial_parallel #(
  parameter int WIDTH = 16,
  parameter int N     = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_parallel_if.slave   bus
);

`ifdef SP_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     count_q;
  logic [FRAME-1:0] shift_q, shift_d;
  logic             sample;
  logic             complete;
  logic             frame_par;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    sample   = 1'b0;
    complete = 1'b0;
    shift_d  = shift_q;

    unique case (state_q)
      IDLE:    if (bus.start) begin
                 state_d = SHIFT;
                 sample  = bus.bit_en;
               end
      SHIFT:   if (!bus.start) state_d = IDLE;
               else            sample  = bus.bit_en;
      HOLD:    if (!bus.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (sample) begin
      for (int i = 0; i < FRAME; i++)
        if (count_q == N'(i)) shift_d[i] = bus.serial_in;
      if (count_q == N'(FRAME - 1)) begin
        complete = 1'b1;
        state_d  = HOLD;
      end
    end

    // Flush outranks everything except reset; the output register is left alone.
    if (bus.clear) begin
      state_d  = IDLE;
      sample   = 1'b0;
      complete = 1'b0;
    end
  end

`ifdef SP_PARITY_EN
  assign frame_par = ^shift_d;
`else
  assign frame_par = 1'b0;
`endif

  assign bus.active = (state_q == SHIFT);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the shift register is reset explicitly; its contents must read back as zero after reset or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      shift_q <= '0;
    end else if (bus.clear) begin
      count_q <= '0;
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
      if (complete || state_d != SHIFT) count_q <= '0;
      else if (sample)                  count_q <= count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.parallel_data <= '0;
      bus.out_valid     <= 1'b0;
      bus.done          <= 1'b0;
      bus.overrun       <= 1'b0;
      bus.parity_err    <= 1'b0;
    end else begin
      bus.done <= complete;

      // A finished word is only taken if the output slot is empty or being emptied this edge.
      if (complete && (!bus.out_valid || bus.out_ready)) begin
        bus.parallel_data <= shift_d[WIDTH-1:0];
        bus.parity_err    <= frame_par;
        bus.out_valid     <= 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (bus.clear)
        bus.overrun <= 1'b0;
      else if (complete && bus.out_valid && !bus.out_ready)
        bus.overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_parallel.sv
// Scoreboard bench for serial_parallel: expected words queued at stimulus, checked on each transfer.
// Honours SP_PARITY_EN the same way as the design.
module tb_serial_parallel;
  localparam int WIDTH = 16;
  localparam int N     = 5;
`ifdef SP_PARITY_EN
  localparam bit PAR   = 1'b1;
  localparam int FRAME = WIDTH + 1;
`else
  localparam bit PAR   = 1'b0;
  localparam int FRAME = WIDTH;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             perr;
  } word_t;

  logic  clk = 1'b0;
  logic  rst_n;
  word_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    done_cnt = 0;
  int    active_cnt = 0;
  int    d0;

  always #5 clk = ~clk;

  serial_parallel_if #(.WIDTH(WIDTH)) bus ();

  serial_parallel #(.WIDTH(WIDTH), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic monitor_xfer();
    word_t w;
    check("xfer_pending", 32'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check("xfer_data", bus.parallel_data, w.data);
      check("xfer_perr", bus.parity_err, w.perr);
    end
  endtask

  // Outputs are observed on the falling edge, half a period away from any update.
  always @(negedge clk) begin
    if (bus.done)   done_cnt++;
    if (bus.active) active_cnt++;
    if (rst_n && bus.out_valid && bus.out_ready) monitor_xfer();
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic pbit,
                           input int lead, input int gap, input bit dropped);
    logic [WIDTH:0]   fx;
    logic [FRAME-1:0] f;
    int               dstart;
    fx     = {pbit, w};
    f      = fx[FRAME-1:0];
    dstart = done_cnt;
    bus.start = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      bus.bit_en = 1'b0;
      cyc((k == 0) ? lead : gap - 1);
      bus.bit_en    = 1'b1;
      bus.serial_in = f[k];
      cyc(1);
    end
    bus.bit_en = 1'b0;
    check("done_now", bus.done, 1);
    check("active_fall", bus.active, 0);
    check("valid_now", bus.out_valid, 1);
    if (!dropped) exp_q.push_back({w, PAR ? ^f : 1'b0});
    bus.start = 1'b0;
    cyc(1);
    check("done_once", done_cnt - dstart, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.serial_in = 1'b0;
    bus.bit_en    = 1'b0;
    bus.start     = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);

    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.parallel_data, 0);
    check("rst_done", bus.done, 0);
    check("rst_active", bus.active, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_perr", bus.parity_err, 0);

    // Basic capture, strobe every cycle.
    send_word(16'hA5C3, 1'b0, 0, 1, 1'b0);
    check("basic_data", bus.parallel_data, 16'hA5C3);
    check("basic_consumed", bus.out_valid, 0);

    // Asynchronous reset mid-word.
    bus.start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.bit_en    = 1'b1;
      bus.serial_in = k[0];
      cyc(1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", bus.parallel_data, 0);
    check("arst_active", bus.active, 0);
    check("arst_valid", bus.out_valid, 0);
    check("arst_done", bus.done, 0);
    bus.start  = 1'b0;
    bus.bit_en = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    send_word(16'hBEEF, 1'b0, 0, 1, 1'b0);

    // Sparse strobe: active spans from the start edge to the final sample edge.
    active_cnt = 0;
    send_word(16'h0001, 1'b0, 1, 4, 1'b0);
    check("sparse_active", active_cnt, 1 + (FRAME - 1) * 4);

    // Abort after 7 bits.
    d0 = done_cnt;
    bus.start = 1'b1;
    for (int k = 0; k < 7; k++) begin
      bus.bit_en    = 1'b1;
      bus.serial_in = 1'b1;
      cyc(1);
    end
    bus.bit_en = 1'b0;
    bus.start  = 1'b0;
    cyc(2);
    check("abort_done", done_cnt - d0, 0);
    check("abort_valid", bus.out_valid, 0);
    check("abort_active", bus.active, 0);
    send_word(16'hFFFF, 1'b0, 0, 1, 1'b0);

    // Clear mid-word with start held: capture must restart at bit 0.
    bus.start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.bit_en    = 1'b1;
      bus.serial_in = 1'b1;
      cyc(1);
    end
    bus.bit_en = 1'b0;
    bus.clear  = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    check("clear_active", bus.active, 0);
    send_word(16'h3C5A, 1'b0, 0, 1, 1'b0);

    // Back-pressure: second word is dropped and flagged.
    bus.out_ready = 1'b0;
    send_word(16'h1234, 1'b0, 0, 1, 1'b0);
    send_word(16'h5678, 1'b0, 0, 1, 1'b1);
    check("bp_overrun", bus.overrun, 1);
    check("bp_data", bus.parallel_data, 16'h1234);
    bus.out_ready = 1'b1;
    cyc(1);
    check("bp_drained", bus.out_valid, 0);
    check("bp_overrun_sticky", bus.overrun, 1);
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    check("bp_overrun_clr", bus.overrun, 0);

    // Parity bit 0 then 1 on the same even-weight word.
    send_word(16'h0003, 1'b0, 0, 1, 1'b0);
    check("par0_err", bus.parity_err, 0);
    send_word(16'h0003, 1'b1, 0, 1, 1'b0);
    check("par1_err", bus.parity_err, PAR ? 1 : 0);
    check("par1_data", bus.parallel_data, 16'h0003);

    cyc(2);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
